ccc_lock_reset_seq: RTL and testbench
=====================================

Name: ccc_lock_reset_seq

Overview:
- Sits directly downstream of the fabric CCC wrapper. Consumes its GL0 clock and its asynchronous LOCK output.
- Qualifies LOCK: synchronises it, then requires it to stay high for a stable window.
- Releases a set of active-low fabric resets one stage at a time, then asserts READY.
- On any loss of lock, collapses all resets immediately and records the event for system software.

Parameters:
- SYNC_STAGES, 2: synchroniser depth on LOCK (minimum 2).
- STABLE_CYCLES, 1024: consecutive synchronised-LOCK-high cycles required before the first release (minimum 1).
- NUM_STAGES, 3: number of sequenced reset outputs (minimum 1).
- STAGE_GAP, 16: cycles between successive stage releases, and between the last release and READY (minimum 1).
- CNT_W, 8: width of the loss-of-lock counter.
- TIMEOUT_CYCLES, 65536: lock watchdog limit (used only with the optional feature).

Ports:
- CLK  in  1  fabric clock; connected to CCC GL0.
- RESET  in  1  synchronous, active-high reset.
- LOCK  in  1  raw CCC lock; asynchronous to CLK.
- CLEAR_LOST  in  1  single-cycle pulse; clears LOCK_LOST.
- RESET_N_OUT  out  NUM_STAGES  per-stage active-low resets; bit 0 releases first.
- READY  out  1  high once all stages are released and lock is held.
- LOCK_LOST  out  1  sticky flag: lock dropped after qualification.
- LOSS_COUNT  out  CNT_W  saturating count of loss events.
- LOCK_TIMEOUT  out  1  sticky watchdog flag; present only with LOCK_TIMEOUT_EN.

Behaviour:
- Clocking and reset: one clock, CLK. RESET is synchronous and active-high.
- Reset values: RESET_N_OUT all 0, READY 0, LOCK_LOST 0, LOSS_COUNT 0, LOCK_TIMEOUT 0, state WAIT_LOCK, all counters 0.
- RESET asserted mid-sequence returns every output to its reset value on the next edge, whatever the state.
- lock_s is LOCK after SYNC_STAGES flops. The synchroniser flops reset to 0. All decisions use lock_s only.
- FSM states: WAIT_LOCK, STABLE, RELEASE, RUN.
- WAIT_LOCK:
  - lock_s=1 -> STABLE, stable counter = 1.
- STABLE:
  - lock_s=1 -> stable counter increments.
  - lock_s=0 -> WAIT_LOCK, counter cleared. This is not a loss event.
  - The counter reaching STABLE_CYCLES -> RELEASE.
- Release timing: let E be the edge at which lock_s is first sampled 1.
  - RESET_N_OUT[0] rises at edge E+STABLE_CYCLES.
  - RESET_N_OUT[k] rises at E+STABLE_CYCLES+k*STAGE_GAP.
  - READY rises at E+STABLE_CYCLES+NUM_STAGES*STAGE_GAP, and the FSM enters RUN.
  - Released bits stay high, monotonically, while lock holds.
- RELEASE or RUN with lock_s=0 (loss event), all at the next edge:
  - RESET_N_OUT all 0 and READY 0.
  - LOCK_LOST set.
  - LOSS_COUNT+1, saturating at all-ones (no wrap).
  - FSM -> WAIT_LOCK; the full stable window must be re-served.
- CLEAR_LOST clears LOCK_LOST on the next edge. If a loss event and CLEAR_LOST occur in the same cycle, set wins.
- LOSS_COUNT clears only on RESET.
- A lock glitch shorter than one CLK period may be missed. This is acceptable.

Optional Feature:
- Macro: CCC_LOCK_RESET_SEQ_LOCK_TIMEOUT_EN.
- When defined:
  - The LOCK_TIMEOUT port exists.
  - A watchdog counts cycles spent in WAIT_LOCK or STABLE since RESET or since the last loss event.
  - Reaching TIMEOUT_CYCLES sets LOCK_TIMEOUT (sticky until RESET).
  - The sequencing itself is unaffected; a later lock still releases normally.
  - The watchdog stops counting once RELEASE is entered.
- When undefined: no port, no watchdog logic.

Decomposition:
- Package ccc_lock_seq_pkg holds:
  - state enum (WAIT_LOCK, STABLE, RELEASE, RUN);
  - a clog2-based counter-width function;
  - default parameter constants.
- One sub-module, ccc_lock_sync: parameterised SYNC_STAGES-deep single-bit synchroniser with synchronous active-high reset.

Test Plan (STABLE_CYCLES=8, STAGE_GAP=4, NUM_STAGES=3, CNT_W=2, SYNC_STAGES=2 unless noted):
- Clean lock: raise LOCK, hold -> RESET_N_OUT 001 at E+8, 011 at E+12, 111 at E+16; READY=1 at E+20; LOSS_COUNT=0.
- Glitch during STABLE: LOCK high 5 cycles, low 3, high again -> no release before new E+8; LOCK_LOST=0; LOSS_COUNT=0.
- Loss in RUN: drop LOCK after READY -> two edges (sync) plus one edge later RESET_N_OUT=000, READY=0, LOCK_LOST=1, LOSS_COUNT=1; re-lock repeats the full 8/4/4/4 sequence.
- Saturation and clear: 4 loss events -> LOSS_COUNT stays 3. CLEAR_LOST pulsed in the same cycle as the 5th loss -> LOCK_LOST remains 1. CLEAR_LOST pulsed alone -> 0.
- Reset mid-RELEASE: RESET asserted when RESET_N_OUT=011 -> next edge all outputs 0, state WAIT_LOCK. With LOCK still high, release restarts from a fresh E.
- Timeout (macro defined, TIMEOUT_CYCLES=50): LOCK held low 60 cycles -> LOCK_TIMEOUT=1 at cycle 50. Later lock -> normal release; LOCK_TIMEOUT stays 1.

Source files
------------

// File: rtl/ccc_lock_seq_pkg.sv
// Shared types, defaults and sizing helper for the CCC lock reset sequencer.
// Optional lock watchdog is enabled by CCC_LOCK_RESET_SEQ_LOCK_TIMEOUT_EN.
package ccc_lock_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN
  } state_t;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_NUM_STAGES     = 3;
  localparam int DEF_STAGE_GAP      = 16;
  localparam int DEF_CNT_W          = 8;
  localparam int DEF_TIMEOUT_CYCLES = 65536;

  // Bits needed to hold the value max_val itself.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ccc_lock_sync.sv
// Multi-flop single-bit synchroniser for the asynchronous CCC LOCK.
// Synchronous active-high reset clears every stage.
module ccc_lock_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic sync
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], sig};
    end
  end

  assign sync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/ccc_lock_reset_seq.sv
// Qualifies CCC LOCK and releases staged active-low resets, then READY.
// Define CCC_LOCK_RESET_SEQ_LOCK_TIMEOUT_EN to add the LOCK_TIMEOUT watchdog.
module ccc_lock_reset_seq
  import ccc_lock_seq_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int NUM_STAGES     = DEF_NUM_STAGES,
  parameter int STAGE_GAP      = DEF_STAGE_GAP,
  parameter int CNT_W          = DEF_CNT_W
`ifdef CCC_LOCK_RESET_SEQ_LOCK_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  LOCK,
  input  logic                  CLEAR_LOST,
  output logic [NUM_STAGES-1:0] RESET_N_OUT,
  output logic                  READY,
  output logic                  LOCK_LOST,
  output logic [CNT_W-1:0]      LOSS_COUNT
`ifdef CCC_LOCK_RESET_SEQ_LOCK_TIMEOUT_EN
  ,
  output logic                  LOCK_TIMEOUT
`endif
);

  localparam int SW = cnt_width(STABLE_CYCLES);
  localparam int GW = cnt_width(STAGE_GAP);

  state_t                state_q;
  state_t                state_d;
  logic [SW-1:0]         stab_q;
  logic [SW-1:0]         stab_d;
  logic [GW-1:0]         gap_q;
  logic [GW-1:0]         gap_d;
  logic [NUM_STAGES-1:0] rst_n_q;
  logic [NUM_STAGES-1:0] rst_n_d;
  logic [NUM_STAGES-1:0] rst_n_shl;
  logic                  ready_q;
  logic                  ready_d;
  logic                  lost_q;
  logic                  lost_d;
  logic [CNT_W-1:0]      loss_q;
  logic [CNT_W-1:0]      loss_d;
  logic                  lock_s;
  logic                  loss_evt;

  ccc_lock_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (CLK),
    .rst (RESET),
    .sig (LOCK),
    .sync(lock_s)
  );

  // Next release pattern: one more low-order stage driven high.
  assign rst_n_shl = NUM_STAGES'({rst_n_q, 1'b1});

  always_comb begin
    state_d  = state_q;
    stab_d   = stab_q;
    gap_d    = gap_q;
    rst_n_d  = rst_n_q;
    ready_d  = ready_q;
    loss_evt = 1'b0;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          stab_d  = SW'(1);
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          stab_d  = '0;
        end else if (stab_q >= SW'(STABLE_CYCLES)) begin
          state_d    = RELEASE;
          stab_d     = '0;
          rst_n_d[0] = 1'b1;
          gap_d      = GW'(1);
        end else begin
          stab_d = stab_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          loss_evt = 1'b1;
        end else if (gap_q >= GW'(STAGE_GAP)) begin
          gap_d = GW'(1);
          if (rst_n_q[NUM_STAGES-1]) begin
            state_d = RUN;
            ready_d = 1'b1;
          end else begin
            rst_n_d = rst_n_shl;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          loss_evt = 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
      end
    endcase

    // Lock lost after qualification: collapse everything at once.
    if (loss_evt) begin
      state_d = WAIT_LOCK;
      stab_d  = '0;
      gap_d   = '0;
      rst_n_d = '0;
      ready_d = 1'b0;
    end

    lost_d = lost_q;
    if (CLEAR_LOST) begin
      lost_d = 1'b0;
    end
    if (loss_evt) begin
      lost_d = 1'b1;
    end

    loss_d = loss_q;
    if (loss_evt && !(&loss_q)) begin
      loss_d = loss_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= WAIT_LOCK;
      stab_q  <= '0;
      gap_q   <= '0;
      rst_n_q <= '0;
      ready_q <= 1'b0;
      lost_q  <= 1'b0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      gap_q   <= gap_d;
      rst_n_q <= rst_n_d;
      ready_q <= ready_d;
      lost_q  <= lost_d;
      loss_q  <= loss_d;
    end
  end

  assign RESET_N_OUT = rst_n_q;
  assign READY       = ready_q;
  assign LOCK_LOST   = lost_q;
  assign LOSS_COUNT  = loss_q;

`ifdef CCC_LOCK_RESET_SEQ_LOCK_TIMEOUT_EN
  localparam int TW = cnt_width(TIMEOUT_CYCLES);

  logic [TW-1:0] wd_q;
  logic [TW-1:0] wd_d;
  logic          to_q;
  logic          to_d;
  logic          waiting;

  assign waiting = (state_q == WAIT_LOCK) || (state_q == STABLE);

  // Watchdog saturates at the limit; the flag stays until RESET.
  always_comb begin
    wd_d = wd_q;
    to_d = to_q;
    if (loss_evt) begin
      wd_d = '0;
    end else if (waiting && (wd_q != TW'(TIMEOUT_CYCLES))) begin
      wd_d = wd_q + 1'b1;
    end
    if (wd_d == TW'(TIMEOUT_CYCLES)) begin
      to_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_d;
      to_q <= to_d;
    end
  end

  assign LOCK_TIMEOUT = to_q;
`endif

endmodule

// File: tb/tb_ccc_lock_reset_seq.sv
// Scoreboard bench for ccc_lock_reset_seq: stimulus queues expectations per
// cycle, a negedge monitor pops and compares them.
module tb_ccc_lock_reset_seq;

  logic       CLK;
  logic       RESET;
  logic       LOCK;
  logic       CLEAR_LOST;
  logic [2:0] RESET_N_OUT;
  logic       READY;
  logic       LOCK_LOST;
  logic [1:0] LOSS_COUNT;
`ifdef CCC_LOCK_RESET_SEQ_LOCK_TIMEOUT_EN
  logic       LOCK_TIMEOUT;
`endif

  ccc_lock_reset_seq #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (8),
    .NUM_STAGES    (3),
    .STAGE_GAP     (4),
    .CNT_W         (2)
`ifdef CCC_LOCK_RESET_SEQ_LOCK_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(50)
`endif
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .LOCK        (LOCK),
    .CLEAR_LOST  (CLEAR_LOST),
    .RESET_N_OUT (RESET_N_OUT),
    .READY       (READY),
    .LOCK_LOST   (LOCK_LOST),
    .LOSS_COUNT  (LOSS_COUNT)
`ifdef CCC_LOCK_RESET_SEQ_LOCK_TIMEOUT_EN
    ,
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
`endif
  );

  typedef struct {
    int         cyc;
    logic [2:0] rn;
    logic       rdy;
    logic       lost;
    logic [1:0] cnt;
    logic       to;
    string      name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  bit   drain = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic push(input int c, input logic [2:0] rn, input logic rdy,
                      input logic lost, input logic [1:0] cnt,
                      input logic to, input string name);
    exp_t e;
    e.cyc = c; e.rn = rn; e.rdy = rdy; e.lost = lost;
    e.cnt = cnt; e.to = to; e.name = name;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Full release sequence for a lock first sampled at edge e.
  task automatic seq_check(input int e, input logic lost, input logic [1:0] cnt,
                           input logic to, input string name);
    push(e + 7,  3'b000, 1'b0, lost, cnt, to, {name, "_e7"});
    push(e + 8,  3'b001, 1'b0, lost, cnt, to, {name, "_e8"});
    push(e + 11, 3'b001, 1'b0, lost, cnt, to, {name, "_e11"});
    push(e + 12, 3'b011, 1'b0, lost, cnt, to, {name, "_e12"});
    push(e + 15, 3'b011, 1'b0, lost, cnt, to, {name, "_e15"});
    push(e + 16, 3'b111, 1'b0, lost, cnt, to, {name, "_e16"});
    push(e + 19, 3'b111, 1'b0, lost, cnt, to, {name, "_e19"});
    push(e + 20, 3'b111, 1'b1, lost, cnt, to, {name, "_e20"});
  endtask

  // Lock, reach first release, then drop lock while in RELEASE.
  task automatic loss_cycle(input logic lost_b, input logic [1:0] cnt_b,
                            input logic [1:0] cnt_a, input logic clr,
                            input string name);
    int e;
    e = cyc + 3;
    push(e + 7,  3'b000, 1'b0, lost_b, cnt_b, 1'b0, {name, "_pre"});
    push(e + 8,  3'b001, 1'b0, lost_b, cnt_b, 1'b0, {name, "_rel"});
    push(e + 11, 3'b001, 1'b0, lost_b, cnt_b, 1'b0, {name, "_hold"});
    push(e + 12, 3'b000, 1'b0, 1'b1,   cnt_a, 1'b0, {name, "_loss"});
    LOCK = 1'b1;
    tick(12);
    LOCK = 1'b0;
    tick(2);
    CLEAR_LOST = clr;
    tick(1);
    CLEAR_LOST = 1'b0;
  endtask

  always @(negedge CLK) begin
    exp_t e;
    logic ok;
    logic to_act;
    while (q.size() > 0 && (drain || q[0].cyc <= cyc)) begin
      e = q.pop_front();
      checks++;
`ifdef CCC_LOCK_RESET_SEQ_LOCK_TIMEOUT_EN
      to_act = LOCK_TIMEOUT;
`else
      to_act = e.to;
`endif
      ok = (e.cyc == cyc) && (RESET_N_OUT === e.rn) && (READY === e.rdy) &&
           (LOCK_LOST === e.lost) && (LOSS_COUNT === e.cnt);
`ifdef CCC_LOCK_RESET_SEQ_LOCK_TIMEOUT_EN
      ok = ok && (LOCK_TIMEOUT === e.to);
`endif
      if (!ok) begin
        errors++;
        $display("FAIL %s cyc=%0d want_cyc=%0d: got rn=%b rdy=%b lost=%b cnt=%0d to=%b, want rn=%b rdy=%b lost=%b cnt=%0d to=%b",
                 e.name, cyc, e.cyc, RESET_N_OUT, READY, LOCK_LOST, LOSS_COUNT,
                 to_act, e.rn, e.rdy, e.lost, e.cnt, e.to);
      end
    end
  end

  initial begin
    int c;
    int e;
    logic rst_ok;
    RESET = 1'b1;
    LOCK = 1'b0;
    CLEAR_LOST = 1'b0;
    tick(3);
    RESET = 1'b0;
    checks++;
    rst_ok = (RESET_N_OUT === 3'b000) && (READY === 1'b0) &&
             (LOCK_LOST === 1'b0) && (LOSS_COUNT === 2'd0);
`ifdef CCC_LOCK_RESET_SEQ_LOCK_TIMEOUT_EN
    rst_ok = rst_ok && (LOCK_TIMEOUT === 1'b0);
`endif
    if (!rst_ok) begin
      errors++;
      $display("FAIL reset_state: rn=%b rdy=%b lost=%b cnt=%0d",
               RESET_N_OUT, READY, LOCK_LOST, LOSS_COUNT);
    end
    push(cyc, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, "reset");

    c = cyc;
    push(c + 11, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, "glitch_norel");
    LOCK = 1'b1;
    tick(5);
    LOCK = 1'b0;
    tick(3);
    LOCK = 1'b1;
    e = cyc + 3;
    seq_check(e, 1'b0, 2'd0, 1'b0, "clean");
    tick(e + 21 - cyc);

    c = cyc;
    LOCK = 1'b0;
    push(c + 2, 3'b111, 1'b1, 1'b0, 2'd0, 1'b0, "run_hold");
    push(c + 3, 3'b000, 1'b0, 1'b1, 2'd1, 1'b0, "run_loss");
    tick(3);
    LOCK = 1'b1;
    e = cyc + 3;
    seq_check(e, 1'b1, 2'd1, 1'b0, "relock");
    tick(e + 21 - cyc);

    c = cyc;
    LOCK = 1'b0;
    push(c + 3, 3'b000, 1'b0, 1'b1, 2'd2, 1'b0, "loss2");
    tick(3);
    loss_cycle(1'b1, 2'd2, 2'd3, 1'b0, "loss3");
    loss_cycle(1'b1, 2'd3, 2'd3, 1'b0, "loss4_sat");
    loss_cycle(1'b1, 2'd3, 2'd3, 1'b1, "loss5_clr");

    c = cyc;
    push(c + 1, 3'b000, 1'b0, 1'b0, 2'd3, 1'b0, "clear");
    CLEAR_LOST = 1'b1;
    tick(1);
    CLEAR_LOST = 1'b0;
    tick(2);

    e = cyc + 3;
    push(e + 13, 3'b011, 1'b0, 1'b0, 2'd3, 1'b0, "pre_rst");
    LOCK = 1'b1;
    tick(16);
    RESET = 1'b1;
    tick(1);
    RESET = 1'b0;
    push(cyc, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, "mid_reset");
    e = cyc + 3;
    seq_check(e, 1'b0, 2'd0, 1'b0, "restart");
    tick(e + 21 - cyc);

`ifdef CCC_LOCK_RESET_SEQ_LOCK_TIMEOUT_EN
    LOCK = 1'b0;
    RESET = 1'b1;
    tick(2);
    RESET = 1'b0;
    c = cyc;
    push(c,      3'b000, 1'b0, 1'b0, 2'd0, 1'b0, "to_reset");
    push(c + 49, 3'b000, 1'b0, 1'b0, 2'd0, 1'b0, "to_before");
    push(c + 50, 3'b000, 1'b0, 1'b0, 2'd0, 1'b1, "to_set");
    tick(60);
    LOCK = 1'b1;
    e = cyc + 3;
    seq_check(e, 1'b0, 2'd0, 1'b1, "to_relock");
    tick(e + 21 - cyc);
`endif

    repeat (50) begin
      if (q.size() > 0) tick(1);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL wait_expired: %0d expectations pending, next %s at %0d",
               q.size(), q[0].name, q[0].cyc);
    end
    drain = 1;
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
